// File: rtl/data_memory_sized.sv
`default_nettype none
// ============================================================================
// data_memory_sized : MIPS byte/half/word data memory, big-endian lanes,
// registered load, misalignment pulse and post-reset clear sweep.
// Revision 1.0
// ============================================================================
module data_memory_sized #(
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [1:0]  access_size,
  input  logic        sign_extend,
  input  logic [31:0] input_addr,
  input  logic [31:0] input_data,
  output logic [31:0] output_data,
  output logic        read_valid,
  output logic        misaligned_error,
  output logic        busy
);

  localparam int WIDX  = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << WIDX;
  localparam logic [WIDX-1:0] LAST_IDX = '1;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WIDX-1:0]   clear_ptr_q, clear_ptr_d;
  logic [31:0]       output_data_q, output_data_d;
  logic              read_valid_q, read_valid_d;
  logic              misaligned_error_q, misaligned_error_d;

  logic [31:0]       mem_q [DEPTH];

  logic [WIDX-1:0]   word_idx;
  logic [1:0]        offset;
  logic              aligned;
  logic              ready;
  logic              do_store;
  logic              do_load;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic              wr_en;
  logic [WIDX-1:0]   wr_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              unused_addr_bits;

  assign word_idx         = input_addr[ADDR_WIDTH-1:2];
  assign offset           = input_addr[1:0];
  assign unused_addr_bits = ^input_addr[31:ADDR_WIDTH];

  always_comb begin
    aligned = 1'b0;
    case (access_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~offset[0];
      2'b10:   aligned = (offset == 2'b00);
      default: aligned = 1'b0;
    endcase

    ready    = (state_q == ST_READY);
    do_store = ready & write_enable & aligned;
    do_load  = ready & read_enable & aligned;

    // Combinational array read before the edge gives old data on a same-cycle store.
    rd_word = mem_q[word_idx];
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = rd_word[31:24];
      2'd1:    byte_sel = rd_word[23:16];
      2'd2:    byte_sel = rd_word[15:8];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = offset[1] ? rd_word[15:0] : rd_word[31:16];

    load_data = rd_word;
    case (access_size)
      2'b00:   load_data = {{24{sign_extend & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{sign_extend & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase

    output_data_d      = do_load ? load_data : output_data_q;
    read_valid_d       = do_load;
    misaligned_error_d = ready & (write_enable | read_enable) & ~aligned;

    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (state_q == ST_CLEAR) begin
      clear_ptr_d = clear_ptr_q + 1'b1;
      if (clear_ptr_q == LAST_IDX) begin
        state_d = ST_READY;
      end
    end

    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_be   = 4'h0;
    wr_data = 32'h0;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clear_ptr_q;
      wr_be   = 4'hF;
      wr_data = 32'h0;
    end else if (do_store) begin
      wr_en = 1'b1;
      // wr_be[3] is the most significant byte lane (offset 0).
      case (access_size)
        2'b00: begin
          wr_be   = 4'b1000 >> offset;
          wr_data = {4{input_data[7:0]}};
        end
        2'b01: begin
          wr_be   = offset[1] ? 4'b0011 : 4'b1100;
          wr_data = {2{input_data[15:0]}};
        end
        default: begin
          wr_be   = 4'hF;
          wr_data = input_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= INIT_CLEAR ? ST_CLEAR : ST_READY;
      clear_ptr_q        <= '0;
      output_data_q      <= 32'h0;
      read_valid_q       <= 1'b0;
      misaligned_error_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      clear_ptr_q        <= clear_ptr_d;
      output_data_q      <= output_data_d;
      read_valid_q       <= read_valid_d;
      misaligned_error_q <= misaligned_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign output_data      = output_data_q;
  assign read_valid       = read_valid_q;
  assign misaligned_error = misaligned_error_q;
  assign busy             = (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`default_nettype none
// ============================================================================
// tb_data_memory_sized : directed + randomized checks against an array model.
// Revision 1.0
// ============================================================================
module tb_data_memory_sized;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [1:0]  access_size = 2'b00;
  logic        sign_extend = 1'b0;
  logic [31:0] input_addr = 32'h0;
  logic [31:0] input_data = 32'h0;
  logic [31:0] output_data;
  logic        read_valid;
  logic        misaligned_error;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_out = 32'h0;

  data_memory_sized #(.ADDR_WIDTH(10), .INIT_CLEAR(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .write_enable     (write_enable),
    .read_enable      (read_enable),
    .access_size      (access_size),
    .sign_extend      (sign_extend),
    .input_addr       (input_addr),
    .input_data       (input_data),
    .output_data      (output_data),
    .read_valid       (read_valid),
    .misaligned_error (misaligned_error),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic bit is_aligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 1'b1;
    if (size == 2'd1) return addr[0] == 1'b0;
    if (size == 2'd2) return addr[1:0] == 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic se,
                                           input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] v;
    int o;
    w = model_mem[addr[9:2]];
    o = int'(addr[1:0]);
    if (size == 2'd0) begin
      v = (w >> (8 * (3 - o))) & 32'hFF;
      if (se && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (w >> (16 * (1 - o / 2))) & 32'hFFFF;
      if (se && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [31:0] mask;
    int o;
    int sh;
    o = int'(addr[1:0]);
    if (size == 2'd0) begin
      sh = 8 * (3 - o);
      mask = 32'hFF << sh;
      model_mem[addr[9:2]] = (model_mem[addr[9:2]] & ~mask) | ((data & 32'hFF) << sh);
    end else if (size == 2'd1) begin
      sh = 16 * (1 - o / 2);
      mask = 32'hFFFF << sh;
      model_mem[addr[9:2]] = (model_mem[addr[9:2]] & ~mask) | ((data & 32'hFFFF) << sh);
    end else begin
      model_mem[addr[9:2]] = data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    access_size  = 2'b00;
    sign_extend  = 1'b0;
  endtask

  // Present one request for a single clock, then release the bus.
  task automatic op(input logic we, input logic re, input logic [1:0] size,
                    input logic se, input logic [31:0] addr, input logic [31:0] data);
    write_enable = we;
    read_enable  = re;
    access_size  = size;
    sign_extend  = se;
    input_addr   = addr;
    input_data   = data;
    step();
    go_idle();
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (output_data !== 32'h0 || read_valid !== 1'b0 || misaligned_error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got data=%h rv=%b err=%b busy=%b required 0/0/0/1",
               output_data, read_valid, misaligned_error, busy);
    end
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL sweep_length: got %0d busy cycles required 256", n);
    end
    clear_model();
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h0);
    checks++;
    if (read_valid !== 1'b1 || output_data !== 32'h0) begin
      errors++;
      $display("FAIL lw_after_clear: got rv=%b data=%h required 1/00000000", read_valid, output_data);
    end
    exp_out = 32'h0;
  endtask

  task automatic test_lanes();
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
    ref_store(2'b10, 32'h10, 32'h1234_5678);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
    checks++;
    if (read_valid !== 1'b1 || output_data !== 32'h12) begin
      errors++;
      $display("FAIL lbu_0x10: got rv=%b data=%h required 1/00000012", read_valid, output_data);
    end
    op(1'b0, 1'b1, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++;
    if (output_data !== 32'h78) begin
      errors++;
      $display("FAIL lb_0x13: got %h required 00000078", output_data);
    end
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0);
    checks++;
    if (output_data !== 32'h5678) begin
      errors++;
      $display("FAIL lhu_0x12: got %h required 00005678", output_data);
    end
    exp_out = 32'h5678;
  endtask

  task automatic test_sub_word();
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'hFFFF_FF80);
    ref_store(2'b00, 32'h21, 32'hFFFF_FF80);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++;
    if (output_data !== 32'h0080_0000) begin
      errors++;
      $display("FAIL sb_word: got %h required 00800000", output_data);
    end
    op(1'b0, 1'b1, 2'b00, 1'b1, 32'h21, 32'h0);
    checks++;
    if (output_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_sext: got %h required ffffff80", output_data);
    end
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0);
    checks++;
    if (output_data !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_zext: got %h required 00000080", output_data);
    end
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF);
    ref_store(2'b01, 32'h22, 32'h1234_BEEF);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++;
    if (output_data !== 32'h0080_BEEF) begin
      errors++;
      $display("FAIL sh_word: got %h required 0080beef", output_data);
    end
    exp_out = 32'h0080_BEEF;
  endtask

  task automatic test_misaligned();
    logic        we_t [3] = '{1'b1, 1'b0, 1'b0};
    logic        re_t [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  sz_t [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad_t [3] = '{32'h02, 32'h01, 32'h00};
    for (int i = 0; i < 3; i++) begin
      op(we_t[i], re_t[i], sz_t[i], 1'b0, ad_t[i], 32'hDEAD_BEEF);
      checks++;
      if (misaligned_error !== 1'b1 || read_valid !== 1'b0 || output_data !== exp_out) begin
        errors++;
        $display("FAIL misalign_%0d: got err=%b rv=%b data=%h required 1/0/%h",
                 i, misaligned_error, read_valid, output_data, exp_out);
      end
      step();
      checks++;
      if (misaligned_error !== 1'b0) begin
        errors++;
        $display("FAIL misalign_pulse_%0d: got err=%b required 0", i, misaligned_error);
      end
    end
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0);
    checks++;
    if (output_data !== model_mem[0]) begin
      errors++;
      $display("FAIL misalign_nowrite: got %h required %h", output_data, model_mem[0]);
    end
    exp_out = model_mem[0];
  endtask

  task automatic test_same_cycle();
    logic [31:0] old;
    old = model_mem[32'h40 >> 2];
    op(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hAAAA_AAAA);
    ref_store(2'b10, 32'h40, 32'hAAAA_AAAA);
    checks++;
    if (read_valid !== 1'b1 || output_data !== old) begin
      errors++;
      $display("FAIL rw_old_data: got rv=%b data=%h required 1/%h", read_valid, output_data, old);
    end
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
    checks++;
    if (output_data !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL rw_new_data: got %h required aaaaaaaa", output_data);
    end
    exp_out = 32'hAAAA_AAAA;
  endtask

  task automatic test_back_to_back();
    logic        we, re, se, ok;
    logic [1:0]  sz;
    logic [31:0] ad, dt, ld;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 3) != 0);
      sz = 2'($urandom_range(0, 3));
      se = 1'($urandom_range(0, 1));
      ad = {$urandom_range(0, 65535), 6'd0, 10'($urandom_range(0, 63))};
      dt = $urandom;
      ok = is_aligned(sz, ad);
      ld = ref_load(sz, se, ad);
      write_enable = we;
      read_enable  = re;
      access_size  = sz;
      sign_extend  = se;
      input_addr   = ad;
      input_data   = dt;
      step();
      if (re && ok) exp_out = ld;
      if (we && ok) ref_store(sz, ad, dt);
      checks++;
      if (read_valid !== (re && ok) || misaligned_error !== ((we || re) && !ok) || output_data !== exp_out) begin
        errors++;
        $display("FAIL random_%0d: got rv=%b err=%b data=%h required %b/%b/%h (we=%b re=%b sz=%0d a=%h)",
                 i, read_valid, misaligned_error, output_data, re && ok, (we || re) && !ok,
                 exp_out, we, re, sz, ad);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'hAAAA_AAAA);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
    reset = 1'b0;
    #1;
    checks++;
    if (output_data !== 32'h0 || read_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got data=%h rv=%b busy=%b required 0/0/1", output_data, read_valid, busy);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op(1'($urandom_range(0, 1)), 1'b1, 2'b10, 1'b0, 32'h40, $urandom);
      checks++;
      if (read_valid !== 1'b0 || misaligned_error !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_drop_%0d: got rv=%b err=%b busy=%b required 0/0/1",
                 i, read_valid, misaligned_error, busy);
      end
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      write_enable = 1'($urandom_range(0, 1));
      read_enable  = 1'b1;
      access_size  = 2'($urandom_range(0, 3));
      input_addr   = 32'($urandom_range(0, 1023));
      input_data   = $urandom;
      step();
      n++;
      if (read_valid !== 1'b0 || misaligned_error !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL sweep_request: got rv=%b err=%b required 0/0", read_valid, misaligned_error);
      end
    end
    go_idle();
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL restart_sweep_length: got %0d busy cycles required 256", n);
    end
    clear_model();
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
    checks++;
    if (read_valid !== 1'b1 || output_data !== 32'h0) begin
      errors++;
      $display("FAIL cleared_0x40: got rv=%b data=%h required 1/00000000", read_valid, output_data);
    end
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h0);
    checks++;
    if (output_data !== 32'h0) begin
      errors++;
      $display("FAIL cleared_0x3fc: got %h required 00000000", output_data);
    end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_sub_word();
    test_misaligned();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
